// File: rtl/cacheline_pkg.sv
// Shared widths, beat index type and FSM encoding for the cacheline adaptor.
package cacheline_pkg;

  localparam int unsigned LINE_W    = 256;
  localparam int unsigned BURST_W   = 64;
  localparam int unsigned BEATS     = LINE_W / BURST_W;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned OFFSET_W  = 5;
  localparam int unsigned BEAT_IDX_W = 2;

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges 256-bit cache line transactions to four 64-bit DRAM beats.
// Define CACHELINE_ADAPTOR_ALIGN_EN to zero the line-offset bits of the latched address.
module cacheline_adaptor
  import cacheline_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  state_e              state_q, state_d;
  beat_idx_t           cnt_q, cnt_d;
  logic [LINE_W-1:0]   buf_q, buf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addr_in;
  logic                read_q, write_q, resp_q;

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
  assign addr_in = {address_i[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
`else
  assign addr_in = address_i;
`endif

  // Next-state, beat counter, line buffer and address register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          state_d = WR_BURST;
          addr_d  = addr_in;
          buf_d   = line_i;
          cnt_d   = '0;
        end else if (read_i) begin
          state_d = RD_BURST;
          addr_d  = addr_in;
          cnt_d   = '0;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          buf_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
          cnt_d = cnt_q + beat_idx_t'(1);
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          cnt_d = cnt_q + beat_idx_t'(1);
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        // Address register doubles as address_o, so it is cleared on the way back to IDLE.
        state_d = IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Request and response strobes are registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      read_q  <= (state_d == RD_BURST);
      write_q <= (state_d == WR_BURST);
      resp_q  <= (state_d == DONE);
    end
  end

  assign line_o    = buf_q;
  assign burst_o   = buf_q[int'(cnt_q)*BURST_W +: BURST_W];
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: read, write, gaps, priority, held request, reset abort.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int tests_run = 0;
  int tests_failed = 0;

  cacheline_adaptor dut (
    .clk(clk), .reset_n(reset_n),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    reset_n = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;
    @(negedge clk);
    tests_run++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_strobes got %b want 000", {read_o, write_o, resp_o});
    end
    tests_run++;
    if (address_o !== 32'h0 || line_o !== 256'h0) begin
      tests_failed++; $display("FAIL reset_data got addr %h line %h want 0", address_o, line_o);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    logic [255:0] exp_line;
    exp_line = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}};
    address_i = 32'h0000_1040; read_i = 1'b1; resp_i = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      tests_run++;
      if (read_o !== 1'b1 || resp_o !== 1'b0 || address_o !== 32'h1040) begin
        tests_failed++;
        $display("FAIL read_beat%0d got rd %b resp %b addr %h want 1 0 1040", b, read_o, resp_o, address_o);
      end
      burst_i = {16{4'(b)}}; resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0;
    tests_run++;
    if (resp_o !== 1'b1 || read_o !== 1'b0 || line_o !== exp_line) begin
      tests_failed++;
      $display("FAIL read_done got resp %b rd %b line %h want 1 0 %h", resp_o, read_o, line_o, exp_line);
    end
    read_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (resp_o !== 1'b0 || address_o !== 32'h0) begin
      tests_failed++; $display("FAIL read_idle got resp %b addr %h want 0 0", resp_o, address_o);
    end
  endtask

  task automatic test_write;
    logic [63:0] exp_beat [4];
    logic        pat [6];
    int          idx;
    exp_beat = '{64'hA, 64'hB, 64'hC, 64'hD};
    pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    idx = 0;
    line_i = {64'hD, 64'hC, 64'hB, 64'hA}; address_i = 32'h0000_2000; write_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== exp_beat[idx]) begin
        tests_failed++;
        $display("FAIL write_step%0d got wr %b rd %b beat %h want 1 0 %h", k, write_o, read_o, burst_o, exp_beat[idx]);
      end
      resp_i = pat[k];
      @(negedge clk);
      if (pat[k]) idx++;
    end
    resp_i = 1'b0;
    tests_run++;
    if (resp_o !== 1'b1 || write_o !== 1'b0 || line_o !== {64'hD, 64'hC, 64'hB, 64'hA}) begin
      tests_failed++; $display("FAIL write_done got resp %b wr %b line %h", resp_o, write_o, line_o);
    end
    write_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (resp_o !== 1'b0 || write_o !== 1'b0) begin
      tests_failed++; $display("FAIL write_single_resp got resp %b wr %b want 0 0", resp_o, write_o);
    end
  endtask

  task automatic test_gapped_read;
    logic        pat [7];
    logic [255:0] exp_line;
    int          idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_line = {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
                64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000};
    idx = 0;
    address_i = 32'h0000_3000; read_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      tests_run++;
      if (read_o !== 1'b1 || resp_o !== 1'b0) begin
        tests_failed++; $display("FAIL gap_step%0d got rd %b resp %b want 1 0", k, read_o, resp_o);
      end
      burst_i = {32'hCAFE_0000, 32'(idx)}; resp_i = pat[k];
      @(negedge clk);
      if (pat[k]) idx++;
    end
    resp_i = 1'b0; read_i = 1'b0;
    tests_run++;
    if (resp_o !== 1'b1 || read_o !== 1'b0 || line_o !== exp_line) begin
      tests_failed++; $display("FAIL gap_done got resp %b rd %b line %h want 1 0 %h", resp_o, read_o, line_o, exp_line);
    end
    @(negedge clk);
    tests_run++;
    if (resp_o !== 1'b0) begin
      tests_failed++; $display("FAIL gap_single_resp got %b want 0", resp_o);
    end
  endtask

  task automatic test_both_requests;
    line_i = {64'h44, 64'h33, 64'h22, 64'h11}; address_i = 32'h0000_4000;
    read_i = 1'b1; write_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== 64'(8'h11 * (k + 1))) begin
        tests_failed++;
        $display("FAIL both_beat%0d got wr %b rd %b beat %h want 1 0 %h", k, write_o, read_o, burst_o, 64'(8'h11 * (k + 1)));
      end
      resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
    tests_run++;
    if (resp_o !== 1'b1 || read_o !== 1'b0) begin
      tests_failed++; $display("FAIL both_done got resp %b rd %b want 1 0", resp_o, read_o);
    end
    @(negedge clk);
  endtask

  task automatic test_held_request;
    address_i = 32'h0000_5000; read_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      burst_i = 64'(k + 16); resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0;
    tests_run++;
    if (resp_o !== 1'b1) begin
      tests_failed++; $display("FAIL held_done got resp %b want 1", resp_o);
    end
    @(negedge clk);
    tests_run++;
    if (resp_o !== 1'b0 || read_o !== 1'b0 || address_o !== 32'h0) begin
      tests_failed++; $display("FAIL held_no_relaunch got resp %b rd %b addr %h want 0 0 0", resp_o, read_o, address_o);
    end
    @(negedge clk);
    tests_run++;
    if (read_o !== 1'b1 || address_o !== 32'h5000) begin
      tests_failed++; $display("FAIL held_idle_launch got rd %b addr %h want 1 5000", read_o, address_o);
    end
    read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0;
    tests_run++;
    if (resp_o !== 1'b1) begin
      tests_failed++; $display("FAIL held_second_done got resp %b want 1", resp_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst;
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    exp_line = {64'h0D0D, 64'h0C0C, 64'h0B0B, 64'h0A0A};
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    exp_addr = 32'h0000_1040;
`else
    exp_addr = 32'h0000_1047;
`endif
    address_i = 32'h0000_6000; read_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      burst_i = 64'hFFFF_0000 + 64'(k); resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0; read_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 || line_o !== 256'h0) begin
      tests_failed++;
      $display("FAIL abort_async got strobes %b addr %h line %h want 000 0 0", {read_o, write_o, resp_o}, address_o, line_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tests_run++;
    if (resp_o !== 1'b0) begin
      tests_failed++; $display("FAIL abort_no_resp got %b want 0", resp_o);
    end
    address_i = 32'h0000_1047; read_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (read_o !== 1'b1 || address_o !== exp_addr) begin
      tests_failed++; $display("FAIL recover_addr got rd %b addr %h want 1 %h", read_o, address_o, exp_addr);
    end
    read_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      burst_i = 64'(16'h0A0A + 16'h0101 * k); resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0;
    tests_run++;
    if (resp_o !== 1'b1 || line_o !== exp_line) begin
      tests_failed++; $display("FAIL recover_line got resp %b line %h want 1 %h", resp_o, line_o, exp_line);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_gapped_read();
    test_both_requests();
    test_held_request();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
